lvds_video_timing_gen: RTL

Video timing and test-pattern source directly upstream of `LVDS_Controller`. It produces 24-bit RGB with HSYNC, VSYNC and DE, one pixel per `pix_ce` strobe, and the controller serializes that pixel word onto the clock pair and data pairs 0–3. The colour switches and the pattern select are captured only at frame start, so a frame never tears.

---
 rtl/lvds_video_pkg.sv | 33 +++
 rtl/lvds_pattern_gen.sv | 42 ++++
 rtl/lvds_video_timing_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lvds_video_pkg.sv
// Shared encodings for the LVDS video timing generator and its pattern source.
package lvds_video_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_CHECK = 2'd3
    } pat_e;

    localparam logic [7:0] COLOR_ON  = 8'hFF;
    localparam logic [7:0] COLOR_OFF = 8'h00;
    localparam logic [2:0] BAR_LAST  = 3'd7;

    // Bar colour table as {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_color(input logic [2:0] idx);
        logic [2:0] c;
        c = 3'b000;
        case (idx)
            3'd0: c = 3'b111;
            3'd1: c = 3'b110;
            3'd2: c = 3'b011;
            3'd3: c = 3'b010;
            3'd4: c = 3'b101;
            3'd5: c = 3'b100;
            3'd6: c = 3'b001;
            3'd7: c = 3'b000;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lvds_pattern_gen.sv
// Combinational test-pattern colour for the pixel currently addressed by the timing core.
module lvds_pattern_gen
    import lvds_video_pkg::*;
(
    input  pat_e       i_pat,
    input  logic [2:0] i_mask,      // {R,G,B} enables
    input  logic [7:0] i_h_lo,      // low byte of the horizontal count
    input  logic       i_v_b5,      // bit 5 of the vertical count
    input  logic [2:0] i_bar_idx,
    output logic [7:0] o_r,
    output logic [7:0] o_g,
    output logic [7:0] o_b
);

    logic [2:0]  w_bar_bits;
    logic        w_cell_on;
    logic [23:0] w_rgb;

    assign w_bar_bits = bar_color(i_bar_idx);
    assign w_cell_on  = i_h_lo[5] ^ i_v_b5;

    // Channel gi: 0 = blue, 1 = green, 2 = red (same order as mask and bar bits).
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [7:0] w_val;

        // Select this channel's level for the active pattern.
        always_comb begin
            w_val = COLOR_OFF;
            case (i_pat)
                PAT_SOLID: w_val = i_mask[gi] ? COLOR_ON : COLOR_OFF;
                PAT_BARS:  w_val = w_bar_bits[gi] ? COLOR_ON : COLOR_OFF;
                PAT_RAMP:  w_val = i_mask[gi] ? i_h_lo : COLOR_OFF;
                PAT_CHECK: w_val = (w_cell_on && i_mask[gi]) ? COLOR_ON : COLOR_OFF;
            endcase
        end

        assign w_rgb[gi*8 +: 8] = w_val;
    end

    assign {o_r, o_g, o_b} = w_rgb;

endmodule

// File: rtl/lvds_video_timing_gen.sv
// Video timing core: pixel counters, sync/DE decode, switch synchronizers,
// per-frame mask/pattern latch and registered pixel outputs.
module lvds_video_timing_gen
    import lvds_video_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       enable,
    input  logic       red_switch,
    input  logic       green_switch,
    input  logic       blue_switch,
    input  logic [1:0] pattern_sel,
    output logic [7:0] pix_r,
    output logic [7:0] pix_g,
    output logic [7:0] pix_b,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters are at least 8 / 6 bits wide so the ramp byte and checker bit always exist.
    localparam int HW    = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
    localparam int VW    = ($clog2(V_TOTAL) > 6) ? $clog2(V_TOTAL) : 6;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] L_H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] L_H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] L_HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] L_HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] L_V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] L_V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] L_VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] L_VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] L_BAR_LAST = BW'(BAR_W - 1);

    logic [4:0]    r_sync1, r_sync2;   // {pattern_sel, R, G, B}
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [BW-1:0] r_bar_pos;
    logic [2:0]    r_bar_idx;
    logic [2:0]    r_mask;
    pat_e          r_pat;
    logic [7:0]    r_r, r_g, r_b;
    logic          r_hs, r_vs, r_de, r_fs;

    logic [4:0] w_async_in;
    logic       w_first, w_de, w_hs_act, w_vs_act;
    logic [2:0] w_mask;
    pat_e       w_pat;
    logic [7:0] w_r, w_g, w_b;

    assign w_async_in = {pattern_sel, red_switch, green_switch, blue_switch};
    assign w_first    = (r_h == '0) && (r_v == '0);
    assign w_de       = (r_h < L_H_ACT) && (r_v < L_V_ACT);
    assign w_hs_act   = (r_h >= L_HS_BEG) && (r_h < L_HS_END);
    assign w_vs_act   = (r_v >= L_VS_BEG) && (r_v < L_VS_END);
    // Pixel (0,0) already uses the values being latched, so the whole frame is consistent.
    assign w_mask     = w_first ? r_sync2[2:0] : r_mask;
    assign w_pat      = w_first ? pat_e'(r_sync2[4:3]) : r_pat;

    // Two-flop synchronizers for the asynchronous panel switches and pattern select.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_async_in;
            r_sync2 <= r_sync1;
        end
    end

    // Pixel/line counters plus the bar sub-counter that stands in for h / BAR_W.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_h       <= '0;
            r_v       <= '0;
            r_bar_pos <= '0;
            r_bar_idx <= '0;
        end else if (pix_ce) begin
            if (!enable) begin
                r_h       <= '0;
                r_v       <= '0;
                r_bar_pos <= '0;
                r_bar_idx <= '0;
            end else if (r_h == L_H_LAST) begin
                r_h       <= '0;
                r_v       <= (r_v == L_V_LAST) ? '0 : r_v + 1'b1;
                r_bar_pos <= '0;
                r_bar_idx <= '0;
            end else begin
                r_h <= r_h + 1'b1;
                if (r_bar_pos == L_BAR_LAST) begin
                    r_bar_pos <= '0;
                    if (r_bar_idx != BAR_LAST)
                        r_bar_idx <= r_bar_idx + 3'd1;
                end else begin
                    r_bar_pos <= r_bar_pos + 1'b1;
                end
            end
        end
    end

    // Frame latch: mask and pattern change only at pixel (0,0).
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
            r_pat  <= PAT_SOLID;
        end else if (pix_ce && enable && w_first) begin
            r_mask <= w_mask;
            r_pat  <= w_pat;
        end
    end

    lvds_pattern_gen u_pattern (
        .i_pat     (w_pat),
        .i_mask    (w_mask),
        .i_h_lo    (r_h[7:0]),
        .i_v_b5    (r_v[5]),
        .i_bar_idx (r_bar_idx),
        .o_r       (w_r),
        .o_g       (w_g),
        .o_b       (w_b)
    );

    // Registered pixel outputs; idle while disabled, blank outside the active area.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_r  <= COLOR_OFF;
            r_g  <= COLOR_OFF;
            r_b  <= COLOR_OFF;
            r_de <= 1'b0;
            r_fs <= 1'b0;
            r_hs <= ~HS_POL;
            r_vs <= ~VS_POL;
        end else if (pix_ce) begin
            if (!enable) begin
                r_r  <= COLOR_OFF;
                r_g  <= COLOR_OFF;
                r_b  <= COLOR_OFF;
                r_de <= 1'b0;
                r_fs <= 1'b0;
                r_hs <= ~HS_POL;
                r_vs <= ~VS_POL;
            end else begin
                r_r  <= w_de ? w_r : COLOR_OFF;
                r_g  <= w_de ? w_g : COLOR_OFF;
                r_b  <= w_de ? w_b : COLOR_OFF;
                r_de <= w_de;
                r_fs <= w_first;
                r_hs <= w_hs_act ? HS_POL : ~HS_POL;
                r_vs <= w_vs_act ? VS_POL : ~VS_POL;
            end
        end
    end

    assign pix_r       = r_r;
    assign pix_g       = r_g;
    assign pix_b       = r_b;
    assign de          = r_de;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign frame_start = r_fs;

endmodule
